axis_vec_pair_tx: RTL and testbench

- Paired AXI-Stream transmitter that feeds the accumulate engine of the dot-product datapath.
- On start, reads two equal-length vectors (Y and Z) from two synchronous RAM ports.
- Emits the vectors beat-aligned on two axis_if master streams, with tlast on the final beat.
- Then waits for the MAC result/valid and returns the captured dot product with a done pulse.

---
 rtl/axis_vec_pair_tx.sv | 191 +++++++++++++++++++
 tb/tb_axis_vec_pair_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_vec_pair_tx.sv
// Reads equal-length Y/Z vectors from two sync RAMs, streams them beat-aligned on two AXI-Stream masters, then captures the MAC result.
// Latency: first tvalid 2 cycles after start is sampled, then 1 beat/cycle; result/done 1 cycle after mac_valid in WAIT.
// Backpressure: a beat moves only when both treadys are high; a 2-entry FIFO with read credit absorbs stalls. Optional timeout: AXIS_VEC_PAIR_TX_TIMEOUT_EN.
module axis_vec_pair_tx #(
   parameter int W  = 32,
   parameter int AW = 10,
   parameter int LW = 16
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic          start,
   input  logic [LW-1:0] length,
   input  logic [AW-1:0] y_base,
   input  logic [AW-1:0] z_base,
   output logic          y_rd_en,
   output logic [AW-1:0] y_rd_addr,
   input  logic [W-1:0]  y_rd_data,
   output logic          z_rd_en,
   output logic [AW-1:0] z_rd_addr,
   input  logic [W-1:0]  z_rd_data,
   output logic [W-1:0]  axis_ay_tdata,
   output logic          axis_ay_tvalid,
   output logic          axis_ay_tlast,
   input  logic          axis_ay_tready,
   output logic [W-1:0]  axis_az_tdata,
   output logic          axis_az_tvalid,
   output logic          axis_az_tlast,
   input  logic          axis_az_tready,
   input  logic [31:0]   mac_result,
   input  logic          mac_valid,
   output logic          busy,
   output logic [31:0]   result,
   output logic          done,
   output logic          err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    state;
   logic [LW-1:0] len_q;
   logic [LW-1:0] issued;
   logic [AW-1:0] y_base_q;
   logic [AW-1:0] z_base_q;
   logic          inflight;
   logic          inflight_last;

   logic [W-1:0]  fifo_y [2];
   logic [W-1:0]  fifo_z [2];
   logic          fifo_l [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    fifo_cnt;

   logic          fifo_vld;
   logic          xfer;
   logic [2:0]    occ;
   logic          rd_go;
   logic          last_rd;

`ifdef AXIS_VEC_PAIR_TX_TIMEOUT_EN
   logic [11:0]   tmo_cnt;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign fifo_vld = (fifo_cnt != 2'd0);
   assign xfer     = fifo_vld & axis_ay_tready & axis_az_tready;
   // Entries already owed to the FIFO: stored + returning next edge - leaving this edge.
   assign occ      = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, xfer};
   assign rd_go    = (state == S_STREAM) && (issued != len_q) && (occ < 3'd2);
   assign last_rd  = (issued == (len_q - LW'(1)));

   assign y_rd_en   = rd_go;
   assign z_rd_en   = rd_go;
   assign y_rd_addr = y_base_q + issued[AW-1:0];
   assign z_rd_addr = z_base_q + issued[AW-1:0];

   assign axis_ay_tvalid = fifo_vld;
   assign axis_az_tvalid = fifo_vld;
   assign axis_ay_tdata  = fifo_y[rd_ptr];
   assign axis_az_tdata  = fifo_z[rd_ptr];
   assign axis_ay_tlast  = fifo_vld & fifo_l[rd_ptr];
   assign axis_az_tlast  = fifo_vld & fifo_l[rd_ptr];

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= S_IDLE;
         len_q    <= '0;
         issued   <= '0;
         y_base_q <= '0;
         z_base_q <= '0;
         result   <= '0;
`ifdef AXIS_VEC_PAIR_TX_TIMEOUT_EN
         tmo_cnt  <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
`ifdef AXIS_VEC_PAIR_TX_TIMEOUT_EN
                  err_q <= 1'b0;
`endif
                  if (length == '0) begin
                     result <= '0;
                     state  <= S_DONE;
                  end else begin
                     len_q    <= length;
                     y_base_q <= y_base;
                     z_base_q <= z_base;
                     issued   <= '0;
                     state    <= S_STREAM;
                  end
               end
            end
            S_STREAM: begin
               if (rd_go) begin
                  issued <= issued + LW'(1);
               end
               if (xfer && fifo_l[rd_ptr]) begin
                  state <= S_WAIT;
`ifdef AXIS_VEC_PAIR_TX_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (mac_valid) begin
                  result <= mac_result;
                  state  <= S_DONE;
               end
`ifdef AXIS_VEC_PAIR_TX_TIMEOUT_EN
               else begin
                  tmo_cnt <= tmo_cnt + 12'd1;
                  // Leave on the edge where the counter reaches 4095.
                  if (tmo_cnt == 12'd4094) begin
                     result <= '0;
                     err_q  <= 1'b1;
                     state  <= S_DONE;
                  end
               end
`endif
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         fifo_cnt      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_y[i] <= '0;
            fifo_z[i] <= '0;
            fifo_l[i] <= 1'b0;
         end
      end else begin
         inflight      <= rd_go;
         inflight_last <= rd_go & last_rd;
         if (inflight) begin
            fifo_y[wr_ptr] <= y_rd_data;
            fifo_z[wr_ptr] <= z_rd_data;
            fifo_l[wr_ptr] <= inflight_last;
            wr_ptr         <= ~wr_ptr;
         end
         if (xfer) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({inflight, xfer})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_vec_pair_tx.sv
// Directed bench for axis_vec_pair_tx: sync RAM and MAC models, beat monitor, one task per scenario.
module tb_axis_vec_pair_tx;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] length = '0;
   logic [9:0]  y_base = '0;
   logic [9:0]  z_base = '0;
   logic        y_rd_en, z_rd_en;
   logic [9:0]  y_rd_addr, z_rd_addr;
   logic [31:0] y_rd_data = '0;
   logic [31:0] z_rd_data = '0;
   logic [31:0] axis_ay_tdata, axis_az_tdata;
   logic        axis_ay_tvalid, axis_az_tvalid, axis_ay_tlast, axis_az_tlast;
   logic        axis_ay_tready = 1'b0;
   logic        axis_az_tready = 1'b0;
   logic [31:0] mac_result = '0;
   logic        mac_valid = 1'b0;
   logic        busy, done, err;
   logic [31:0] result;

   int total = 0;
   int bad = 0;

   axis_vec_pair_tx dut (
      .aclk(aclk), .aresetn(aresetn), .start(start), .length(length),
      .y_base(y_base), .z_base(z_base),
      .y_rd_en(y_rd_en), .y_rd_addr(y_rd_addr), .y_rd_data(y_rd_data),
      .z_rd_en(z_rd_en), .z_rd_addr(z_rd_addr), .z_rd_data(z_rd_data),
      .axis_ay_tdata(axis_ay_tdata), .axis_ay_tvalid(axis_ay_tvalid),
      .axis_ay_tlast(axis_ay_tlast), .axis_ay_tready(axis_ay_tready),
      .axis_az_tdata(axis_az_tdata), .axis_az_tvalid(axis_az_tvalid),
      .axis_az_tlast(axis_az_tlast), .axis_az_tready(axis_az_tready),
      .mac_result(mac_result), .mac_valid(mac_valid),
      .busy(busy), .result(result), .done(done), .err(err)
   );

   always #5 aclk = ~aclk;

   logic [31:0] ram_y [0:1023];
   logic [31:0] ram_z [0:1023];

   always @(posedge aclk) begin
      if (y_rd_en) y_rd_data <= ram_y[y_rd_addr];
      if (z_rd_en) z_rd_data <= ram_z[z_rd_addr];
   end

   // Monitor: every transferred beat, read strobes, visible tvalid cycles and lane disagreements.
   int          n_rx = 0, n_last = 0, n_rd = 0, n_vld = 0, n_mis = 0;
   logic [31:0] rx_y [0:255];
   logic [31:0] rx_z [0:255];
   logic        rx_l [0:255];

   always @(posedge aclk) begin
      if (aresetn) begin
         if (y_rd_en) n_rd <= n_rd + 1;
         if (axis_ay_tvalid | axis_az_tvalid) n_vld <= n_vld + 1;
         if ((y_rd_en != z_rd_en) || (axis_ay_tvalid != axis_az_tvalid) ||
             (axis_ay_tvalid && (axis_ay_tlast != axis_az_tlast)))
            n_mis <= n_mis + 1;
         if (axis_ay_tvalid && axis_ay_tready && axis_az_tready) begin
            rx_y[8'(n_rx)] <= axis_ay_tdata;
            rx_z[8'(n_rx)] <= axis_az_tdata;
            rx_l[8'(n_rx)] <= axis_ay_tlast;
            n_rx <= n_rx + 1;
            if (axis_ay_tlast) n_last <= n_last + 1;
         end
      end
   end

   task automatic load_vec(input logic [9:0] yb, input logic [9:0] zb, input int n,
                           input int y0, input int z0);
      for (int i = 0; i < n; i++) begin
         ram_y[yb + 10'(i)] = 32'(y0 + i);
         ram_z[zb + 10'(i)] = 32'(z0 + i);
      end
   endtask

   task automatic do_start(input logic [15:0] len, input logic [9:0] yb, input logic [9:0] zb);
      start = 1'b1; length = len; y_base = yb; z_base = zb;
      @(negedge aclk);
      start = 1'b0;
   endtask

   // MAC model: after the tlast beat, return sum(y*z) over the received beats, then measure done width.
   task automatic wait_mac_done(input int n0, input int n, input int l0,
                                output int dl, output bit ok);
      logic [31:0] acc;
      int          k;
      dl = 0; ok = 1'b0; acc = '0; k = 0;
      while (n_last <= l0 && k < 300) begin
         @(negedge aclk);
         k++;
      end
      if (n_last <= l0) return;
      for (int i = 0; i < n; i++) acc += rx_y[8'(n0 + i)] * rx_z[8'(n0 + i)];
      mac_result = acc; mac_valid = 1'b1;
      @(negedge aclk);
      mac_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (done) dl++;
         else if (dl > 0) break;
         @(negedge aclk);
      end
      ok = (dl > 0);
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      total++;
      if ({busy, done, err, axis_ay_tvalid, axis_az_tvalid, axis_ay_tlast, axis_az_tlast, y_rd_en, z_rd_en} !== 9'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 000000000", {busy, done, err, axis_ay_tvalid, axis_az_tvalid, axis_ay_tlast, axis_az_tlast, y_rd_en, z_rd_en});
      end
      total++;
      if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
      aresetn = 1'b1;
      repeat (2) @(negedge aclk);
      total++;
      if ({busy, axis_ay_tvalid, y_rd_en} !== 3'b0) begin
         bad++; $display("FAIL reset_idle: got %b want 000", {busy, axis_ay_tvalid, y_rd_en});
      end
   endtask

   task automatic test_basic();
      int n0, l0, r0, m0, dl; bit ok;
      n0 = n_rx; l0 = n_last; r0 = n_rd; m0 = n_mis;
      load_vec(10'h010, 10'h200, 4, 1, 5);
      axis_ay_tready = 1'b1; axis_az_tready = 1'b1;
      do_start(16'd4, 10'h010, 10'h200);
      total++;
      if ({y_rd_en, z_rd_en, y_rd_addr, z_rd_addr, axis_ay_tvalid} !== {2'b11, 10'h010, 10'h200, 1'b0}) begin
         bad++; $display("FAIL basic_first_read: got en=%b%b addr=%h/%h vld=%b want 11 010/200 0", y_rd_en, z_rd_en, y_rd_addr, z_rd_addr, axis_ay_tvalid);
      end
      @(negedge aclk);
      total++;
      if (axis_ay_tvalid !== 1'b0) begin bad++; $display("FAIL basic_vld_cycle1: got %b want 0", axis_ay_tvalid); end
      @(negedge aclk);
      total++;
      if ({axis_ay_tvalid, axis_az_tvalid, axis_ay_tdata, axis_az_tdata} !== {2'b11, 32'd1, 32'd5}) begin
         bad++; $display("FAIL basic_vld_cycle2: got vld=%b%b y=%0d z=%0d want 11 1 5", axis_ay_tvalid, axis_az_tvalid, axis_ay_tdata, axis_az_tdata);
      end
      wait_mac_done(n0, 4, l0, dl, ok);
      total++;
      if (!ok || dl != 1) begin bad++; $display("FAIL basic_done_pulse: got ok=%0d width=%0d want 1 1", ok, dl); end
      total++;
      if (result !== 32'd70) begin bad++; $display("FAIL basic_result: got %0d want 70", result); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
      total++;
      if (n_rx - n0 != 4 || n_rd - r0 != 4 || n_mis != m0) begin
         bad++; $display("FAIL basic_counts: got beats=%0d reads=%0d mis=%0d want 4 4 0", n_rx - n0, n_rd - r0, n_mis - m0);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rx_y[8'(n0 + k)] !== 32'(1 + k) || rx_z[8'(n0 + k)] !== 32'(5 + k) || rx_l[8'(n0 + k)] !== (k == 3)) begin
            bad++; $display("FAIL basic_beat%0d: got %0d/%0d/%b want %0d/%0d/%b", k, rx_y[8'(n0 + k)], rx_z[8'(n0 + k)], rx_l[8'(n0 + k)], 1 + k, 5 + k, k == 3);
         end
      end
   endtask

   task automatic test_random_ready();
      int n0, l0, dl, stab_bad, stalls; bit ok, prev_stall;
      logic [31:0] pat_a, pat_z, sy, sz; logic sl;
      n0 = n_rx; l0 = n_last; stab_bad = 0; stalls = 0; prev_stall = 1'b0;
      pat_a = 32'hB5D3_6E29; pat_z = 32'h9C6A_D3B7; sy = '0; sz = '0; sl = 1'b0;
      axis_ay_tready = 1'b0; axis_az_tready = 1'b0;
      do_start(16'd4, 10'h010, 10'h200);
      for (int c = 0; c < 200 && (n_rx - n0) < 4; c++) begin
         if (prev_stall) begin
            if (axis_ay_tvalid !== 1'b1 || axis_az_tvalid !== 1'b1 || axis_ay_tdata !== sy ||
                axis_az_tdata !== sz || axis_ay_tlast !== sl || axis_az_tlast !== sl)
               stab_bad++;
         end
         axis_ay_tready = pat_a[c % 32];
         axis_az_tready = pat_z[(c + 7) % 32];
         prev_stall = axis_ay_tvalid && !(axis_ay_tready && axis_az_tready);
         if (prev_stall) stalls++;
         sy = axis_ay_tdata; sz = axis_az_tdata; sl = axis_ay_tlast;
         @(negedge aclk);
      end
      axis_ay_tready = 1'b1; axis_az_tready = 1'b1;
      wait_mac_done(n0, 4, l0, dl, ok);
      total++;
      if (stab_bad != 0 || stalls == 0) begin bad++; $display("FAIL rand_stable: got violations=%0d stalls=%0d want 0 and >0", stab_bad, stalls); end
      total++;
      if (n_rx - n0 != 4) begin bad++; $display("FAIL rand_count: got %0d want 4", n_rx - n0); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rx_y[8'(n0 + k)] !== 32'(1 + k) || rx_z[8'(n0 + k)] !== 32'(5 + k) || rx_l[8'(n0 + k)] !== (k == 3)) begin
            bad++; $display("FAIL rand_beat%0d: got %0d/%0d/%b want %0d/%0d/%b", k, rx_y[8'(n0 + k)], rx_z[8'(n0 + k)], rx_l[8'(n0 + k)], 1 + k, 5 + k, k == 3);
         end
      end
      total++;
      if (!ok || result !== 32'd70) begin bad++; $display("FAIL rand_result: got ok=%0d result=%0d want 1 70", ok, result); end
   endtask

   task automatic test_one_ready();
      int n0, l0, r0, dl; bit ok;
      n0 = n_rx; l0 = n_last; r0 = n_rd;
      axis_ay_tready = 1'b1; axis_az_tready = 1'b0;
      do_start(16'd4, 10'h010, 10'h200);
      repeat (10) @(negedge aclk);
      total++;
      if (n_rx - n0 != 0 || n_rd - r0 != 2) begin
         bad++; $display("FAIL one_ready_hold: got beats=%0d reads=%0d want 0 2", n_rx - n0, n_rd - r0);
      end
      total++;
      if ({axis_ay_tvalid, axis_az_tvalid, axis_ay_tlast, axis_ay_tdata, axis_az_tdata} !== {3'b110, 32'd1, 32'd5}) begin
         bad++; $display("FAIL one_ready_head: got vld=%b%b last=%b y=%0d z=%0d want 11 0 1 5", axis_ay_tvalid, axis_az_tvalid, axis_ay_tlast, axis_ay_tdata, axis_az_tdata);
      end
      axis_az_tready = 1'b1;
      @(negedge aclk);
      total++;
      if (n_rx - n0 != 1 || rx_y[8'(n0)] !== 32'd1 || rx_z[8'(n0)] !== 32'd5) begin
         bad++; $display("FAIL one_ready_release: got beats=%0d first=%0d/%0d want 1 1/5", n_rx - n0, rx_y[8'(n0)], rx_z[8'(n0)]);
      end
      wait_mac_done(n0, 4, l0, dl, ok);
      total++;
      if (!ok || n_rx - n0 != 4 || result !== 32'd70) begin
         bad++; $display("FAIL one_ready_finish: got ok=%0d beats=%0d result=%0d want 1 4 70", ok, n_rx - n0, result);
      end
   endtask

   task automatic test_zero_len();
      int r0, v0, k;
      r0 = n_rd; v0 = n_vld; k = 0;
      axis_ay_tready = 1'b1; axis_az_tready = 1'b1;
      do_start(16'd0, 10'h010, 10'h200);
      while (!done && k < 2) begin
         @(negedge aclk);
         k++;
      end
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
      total++;
      if (result !== 32'd0) begin bad++; $display("FAIL zero_result: got %0d want 0", result); end
      @(negedge aclk);
      total++;
      if (n_rd != r0 || n_vld != v0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL zero_quiet: got reads=%0d vld=%0d busy=%b done=%b want 0 0 0 0", n_rd - r0, n_vld - v0, busy, done);
      end
   endtask

   task automatic test_start_while_busy();
      int n0, l0, r0, dl; bit ok;
      n0 = n_rx; l0 = n_last; r0 = n_rd;
      axis_ay_tready = 1'b1; axis_az_tready = 1'b1;
      do_start(16'd4, 10'h010, 10'h200);
      repeat (2) @(negedge aclk);
      start = 1'b1; length = 16'd2; y_base = 10'h3FE; z_base = 10'h100;
      mac_result = 32'd999; mac_valid = 1'b1;
      @(negedge aclk);
      start = 1'b0; mac_valid = 1'b0;
      wait_mac_done(n0, 4, l0, dl, ok);
      total++;
      if (!ok || n_rx - n0 != 4 || n_rd - r0 != 4) begin
         bad++; $display("FAIL busy_start_counts: got ok=%0d beats=%0d reads=%0d want 1 4 4", ok, n_rx - n0, n_rd - r0);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rx_y[8'(n0 + k)] !== 32'(1 + k) || rx_z[8'(n0 + k)] !== 32'(5 + k)) begin
            bad++; $display("FAIL busy_start_beat%0d: got %0d/%0d want %0d/%0d", k, rx_y[8'(n0 + k)], rx_z[8'(n0 + k)], 1 + k, 5 + k);
         end
      end
      total++;
      if (result !== 32'd70) begin bad++; $display("FAIL busy_start_result: got %0d want 70", result); end
   endtask

   task automatic test_reset_mid();
      int n0, n1, l1, dl, k; bit ok;
      n0 = n_rx; k = 0;
      load_vec(10'h3FE, 10'h100, 8, 11, 21);
      axis_ay_tready = 1'b1; axis_az_tready = 1'b1;
      do_start(16'd8, 10'h3FE, 10'h100);
      while ((n_rx - n0) < 2 && k < 50) begin
         @(negedge aclk);
         k++;
      end
      total++;
      if (n_rx - n0 != 2 || axis_ay_tvalid !== 1'b1 || axis_ay_tdata !== 32'd13) begin
         bad++; $display("FAIL rst_mid_before: got beats=%0d vld=%b y=%0d want 2 1 13", n_rx - n0, axis_ay_tvalid, axis_ay_tdata);
      end
      aresetn = 1'b0;
      #1;
      total++;
      if ({axis_ay_tvalid, axis_az_tvalid, busy, y_rd_en} !== 4'b0 || result !== 32'd0) begin
         bad++; $display("FAIL rst_mid_async: got vld=%b%b busy=%b en=%b result=%0d want 0000 0", axis_ay_tvalid, axis_az_tvalid, busy, y_rd_en, result);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      n1 = n_rx; l1 = n_last;
      total++;
      if (n1 - n0 != 2) begin bad++; $display("FAIL rst_mid_no_more: got %0d want 2", n1 - n0); end
      do_start(16'd8, 10'h3FE, 10'h100);
      wait_mac_done(n1, 8, l1, dl, ok);
      total++;
      if (!ok || n_rx - n1 != 8) begin bad++; $display("FAIL rst_mid_restart: got ok=%0d beats=%0d want 1 8", ok, n_rx - n1); end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (rx_y[8'(n1 + j)] !== 32'(11 + j) || rx_z[8'(n1 + j)] !== 32'(21 + j) || rx_l[8'(n1 + j)] !== (j == 7)) begin
            bad++; $display("FAIL rst_mid_beat%0d: got %0d/%0d/%b want %0d/%0d/%b", j, rx_y[8'(n1 + j)], rx_z[8'(n1 + j)], rx_l[8'(n1 + j)], 11 + j, 21 + j, j == 7);
         end
      end
      total++;
      if (result !== 32'd2884) begin bad++; $display("FAIL rst_mid_result: got %0d want 2884", result); end
   endtask

`ifdef AXIS_VEC_PAIR_TX_TIMEOUT_EN
   task automatic test_timeout();
      int n0, l0, k, cyc, dl; bit ok;
      n0 = n_rx; l0 = n_last; k = 0; cyc = 0;
      axis_ay_tready = 1'b1; axis_az_tready = 1'b1;
      do_start(16'd1, 10'h010, 10'h200);
      while (n_last <= l0 && k < 50) begin
         @(negedge aclk);
         k++;
      end
      while (!done && cyc < 5000) begin
         @(negedge aclk);
         cyc++;
      end
      total++;
      if (done !== 1'b1 || cyc != 4095) begin bad++; $display("FAIL timeout_cycles: got done=%b after %0d want 1 after 4095", done, cyc); end
      total++;
      if (err !== 1'b1 || result !== 32'd0) begin bad++; $display("FAIL timeout_flags: got err=%b result=%0d want 1 0", err, result); end
      @(negedge aclk);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL timeout_err_hold: got %b want 1", err); end
      n0 = n_rx; l0 = n_last;
      do_start(16'd4, 10'h010, 10'h200);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL timeout_err_clear: got %b want 0", err); end
      wait_mac_done(n0, 4, l0, dl, ok);
      total++;
      if (!ok || result !== 32'd70) begin bad++; $display("FAIL timeout_next_op: got ok=%0d result=%0d want 1 70", ok, result); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_random_ready();
      test_one_ready();
      test_zero_len();
      test_start_while_busy();
      test_reset_mid();
`ifdef AXIS_VEC_PAIR_TX_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
